// File: rtl/multicycle_mem_responder.sv
// Unified instruction/data memory for the multicycle core: request latch, programmable
// wait states, RV32 byte/half/word lanes, load extension and misalignment errors.
module multicycle_mem_responder #(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        iord,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, err_q_unused_pad;
  logic        err_q;

  logic [31:0] addr_q, wdata_q;
  logic [2:0]  funct3_q;
  logic        iord_q, rd_q, wr_q;

  logic [31:0] mem_q [DEPTH];

  logic              take, go_resp, acc_err, we;
  logic [31:0]       cur_addr, cur_wdata, rd_word;
  logic [2:0]        cur_f3;
  logic              cur_iord, cur_rd, cur_wr;
  logic [IDX_W-1:0]  word_idx;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              unused_addr_hi;

  function automatic logic access_err(input logic rd, input logic wr, input logic id,
                                      input logic [2:0] f3, input logic [1:0] a);
    logic e;
    if (rd && wr)   e = 1'b1;
    else if (!id)   e = (a != 2'b00);
    else begin
      case (f3)
        3'b000, 3'b100: e = 1'b0;
        3'b001, 3'b101: e = a[0];
        3'b010:         e = (a != 2'b00);
        default:        e = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic id,
                                           input logic [2:0] f3, input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = $signed(w[{a, 3'b000} +: 8]);
    h = $signed(w[{a[1], 4'b0000} +: 16]);
    r = w;
    if (id) begin
      case (f3)
        3'b000:  r = {{24{b[7]}}, b};
        3'b001:  r = {{16{h[15]}}, h};
        3'b100:  r = {24'd0, b};
        3'b101:  r = {16'd0, h};
        default: r = w;
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic id, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic [3:0] be;
    be = 4'hF;
    if (id) begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << a;
        2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
        default: be = 4'hF;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic id, input logic [2:0] f3,
                                             input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (id) begin
      case (f3[1:0])
        2'b00:   r = {4{d[7:0]}};
        2'b01:   r = {2{d[15:0]}};
        default: r = d;
      endcase
    end
    return r;
  endfunction

  assign err_q_unused_pad = '0;

  // With zero wait states the access happens on the sampling edge, so the live
  // inputs stand in for the not-yet-latched request.
  always_comb begin
    take      = (state_q == IDLE) && (mem_read || mem_write);
    cur_addr  = (state_q == IDLE) ? addr      : addr_q;
    cur_wdata = (state_q == IDLE) ? wdata     : wdata_q;
    cur_f3    = (state_q == IDLE) ? funct3    : funct3_q;
    cur_iord  = (state_q == IDLE) ? iord      : iord_q;
    cur_rd    = (state_q == IDLE) ? mem_read  : rd_q;
    cur_wr    = (state_q == IDLE) ? mem_write : wr_q;
  end

  assign go_resp  = (take && (WAIT_STATES == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));
  assign word_idx = cur_addr[IDX_W+1:2];
  assign rd_word  = mem_q[word_idx];
  assign acc_err  = access_err(cur_rd, cur_wr, cur_iord, cur_f3, cur_addr[1:0]);
  assign st_be    = store_be(cur_iord, cur_f3, cur_addr[1:0]);
  assign st_data  = store_data(cur_iord, cur_f3, cur_wdata);
  assign we       = go_resp && cur_wr && !acc_err && !reset;
  assign unused_addr_hi = ^{cur_addr[31:IDX_W+2], err_q_unused_pad};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
          cnt_d   = WS_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch: data only, no reset
  always_ff @(posedge clk) begin
    if (take) begin
      addr_q   <= addr;
      wdata_q  <= wdata;
      funct3_q <= funct3;
      iord_q   <= iord;
      rd_q     <= mem_read;
      wr_q     <= mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // Response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (go_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || cur_wr) ? 32'd0 : load_fmt(rd_word, cur_iord, cur_f3, cur_addr[1:0]);
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ready = (state_q == RESP);
  assign busy  = (state_q == WAIT);

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Scoreboard bench for multicycle_mem_responder: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance driven by one request task; responses checked on ready.
module tb_multicycle_mem_responder;

  localparam int WS_SLOW = 2;
  localparam int DEPTH   = 1024;

  logic clk, reset;

  logic        s_rd, s_wr, s_iord, s_ready, s_busy, s_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [2:0]  s_f3;

  logic        f_rd, f_wr, f_iord, f_ready, f_busy, f_err;
  logic [31:0] f_addr, f_wdata, f_rdata;
  logic [2:0]  f_f3;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  multicycle_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_SLOW), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .mem_read(s_rd), .mem_write(s_wr), .iord(s_iord),
    .addr(s_addr), .wdata(s_wdata), .funct3(s_f3),
    .rdata(s_rdata), .ready(s_ready), .busy(s_busy), .err(s_err)
  );

  multicycle_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .INIT_FILE("")) dut_fast (
    .clk(clk), .reset(reset), .mem_read(f_rd), .mem_write(f_wr), .iord(f_iord),
    .addr(f_addr), .wdata(f_wdata), .funct3(f_f3),
    .rdata(f_rdata), .ready(f_ready), .busy(f_busy), .err(f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response monitor: every ready pulse pops one expectation
  always @(posedge clk) begin
    #1;
    if (s_ready || f_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        chk("rdata", s_ready ? s_rdata : f_rdata, x.d);
        chk("err", {31'd0, s_ready ? s_err : f_err}, {31'd0, x.e});
      end
    end
  end

  task automatic io(input bit fast, input logic rd, input logic wr, input logic id,
                    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] ed, input logic ee);
    int n;
    int lat;
    logic r;
    lat = fast ? 1 : WS_SLOW + 1;
    sb_q.push_back('{d: ed, e: ee});
    @(negedge clk);
    if (fast) begin
      f_rd = rd; f_wr = wr; f_iord = id; f_f3 = f3; f_addr = a; f_wdata = wd;
    end else begin
      s_rd = rd; s_wr = wr; s_iord = id; s_f3 = f3; s_addr = a; s_wdata = wd;
    end
    @(posedge clk);
    #1;
    // Request sampled; scramble inputs so only latched values can matter
    if (fast) begin
      f_rd = 0; f_wr = 0; f_iord = 1'($urandom); f_f3 = 3'($urandom);
      f_addr = $urandom; f_wdata = $urandom;
    end else begin
      s_rd = 0; s_wr = 0; s_iord = 1'($urandom); s_f3 = 3'($urandom);
      s_addr = $urandom; s_wdata = $urandom;
    end
    n = 1;
    r = fast ? f_ready : s_ready;
    while (!r && n < 40) begin
      if (!fast) chk("busy_wait", {31'd0, s_busy}, 32'd1);
      @(posedge clk);
      #1;
      n++;
      r = fast ? f_ready : s_ready;
    end
    if (!r) begin
      chk("ready_timeout", 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
    chk("latency", n, lat);
    chk("busy_resp", {31'd0, fast ? f_busy : s_busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_pulse", {31'd0, fast ? f_ready : s_ready}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    s_rd = 0; s_wr = 0; s_iord = 0; s_f3 = 0; s_addr = 0; s_wdata = 0;
    f_rd = 0; f_wr = 0; f_iord = 0; f_f3 = 0; f_addr = 0; f_wdata = 0;
    #12;
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_flags", {29'd0, s_ready, s_busy, s_err}, 32'd0);
    chk("rst_fast", {f_rdata[28:0], f_ready, f_busy, f_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Program word 0, then fetch it
    io(0, 0, 1, 1, 3'b010, 32'h0,  32'h00500093, 32'h0, 0);
    io(0, 1, 0, 0, 3'b111, 32'h0,  32'h0,        32'h00500093, 0);

    // Store lanes and load extension
    io(0, 0, 1, 1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 0);
    io(0, 0, 1, 1, 3'b000, 32'h41, 32'hAAAAAA11, 32'h0, 0);
    io(0, 1, 0, 1, 3'b010, 32'h40, 32'h0, 32'hDEAD11EF, 0);
    io(0, 1, 0, 1, 3'b000, 32'h43, 32'h0, 32'hFFFFFFDE, 0);
    io(0, 1, 0, 1, 3'b100, 32'h43, 32'h0, 32'h000000DE, 0);
    io(0, 1, 0, 1, 3'b001, 32'h42, 32'h0, 32'hFFFFDEAD, 0);
    io(0, 1, 0, 1, 3'b101, 32'h42, 32'h0, 32'h0000DEAD, 0);
    io(0, 1, 0, 1, 3'b000, 32'h41, 32'h0, 32'h00000011, 0);
    io(0, 1, 0, 1, 3'b001, 32'h40, 32'h0, 32'h000011EF, 0);
    io(0, 0, 1, 1, 3'b001, 32'h42, 32'h12345678, 32'h0, 0);
    io(0, 1, 0, 1, 3'b010, 32'h40, 32'h0, 32'h567811EF, 0);

    // Misaligned, invalid funct3; memory must be untouched
    io(0, 1, 0, 1, 3'b010, 32'h42, 32'h0, 32'h0, 1);
    io(0, 0, 1, 1, 3'b001, 32'h41, 32'hFFFFFFFF, 32'h0, 1);
    io(0, 0, 1, 1, 3'b010, 32'h43, 32'hFFFFFFFF, 32'h0, 1);
    io(0, 1, 0, 0, 3'b010, 32'h6,  32'h0, 32'h0, 1);
    io(0, 1, 0, 1, 3'b011, 32'h40, 32'h0, 32'h0, 1);
    io(0, 0, 1, 1, 3'b110, 32'h40, 32'h0, 32'h0, 1);
    io(0, 1, 0, 1, 3'b010, 32'h40, 32'h0, 32'h567811EF, 0);

    // Simultaneous read and write
    io(0, 0, 1, 1, 3'b010, 32'h80, 32'hCAFEF00D, 32'h0, 0);
    io(0, 1, 1, 1, 3'b010, 32'h80, 32'h0BADBEEF, 32'h0, 1);
    io(0, 1, 0, 1, 3'b010, 32'h80, 32'h0, 32'hCAFEF00D, 0);

    // Reset during WAIT aborts a store
    io(0, 0, 1, 1, 3'b010, 32'h100, 32'h12345678, 32'h0, 0);
    @(negedge clk);
    s_rd = 0; s_wr = 1; s_iord = 1; s_f3 = 3'b010; s_addr = 32'h100; s_wdata = 32'h55AA55AA;
    @(posedge clk);
    #1;
    s_wr = 0;
    chk("abort_busy_pre", {31'd0, s_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, s_busy}, 32'd0);
    chk("abort_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    io(0, 1, 0, 1, 3'b010, 32'h100, 32'h0, 32'h12345678, 0);

    // Zero-wait-state instance: single-cycle latency and address aliasing
    io(1, 0, 1, 1, 3'b010, 32'h0, 32'h00000013, 32'h0, 0);
    io(1, 0, 1, 1, 3'b010, 32'h4, 32'h00A00113, 32'h0, 0);
    io(1, 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h00000013, 0);
    io(1, 1, 0, 0, 3'b000, 32'h4, 32'h0, 32'h00A00113, 0);
    io(1, 0, 1, 1, 3'b010, 32'h40 + 4 * DEPTH, 32'hA5A5A5A5, 32'h0, 0);
    io(1, 1, 0, 1, 3'b010, 32'h40, 32'h0, 32'hA5A5A5A5, 0);
    io(1, 1, 0, 1, 3'b000, 32'hFFFF0041, 32'h0, 32'hFFFFFFA5, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
